// File: rtl/video_frame_reader.sv
// Avalon-MM burst read master: fetches one frame of pixel words into a credit-gated FWFT FIFO
// drained by a ready/valid pixel stream. Optional macro VFR_UNDERFLOW_CNT_EN adds underflow_cnt.
module video_frame_reader #(
  parameter int DATA_W     = 32,
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       frame_base,
  input  logic [23:0]       frame_words,
  output logic              busy,
  output logic              done,
  output logic [31:0]       avm_address,
  output logic              avm_read,
  output logic [8:0]        avm_burstcount,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready
`ifdef VFR_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_REQ    = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_addr;
  logic [23:0]         r_remaining;
  logic [CW-1:0]       r_outstanding;
  logic [CW-1:0]       r_fifo_count;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic                r_busy;
  logic                r_done;
  logic                r_avm_read;
  logic [31:0]         r_avm_address;
  logic [8:0]          r_avm_burstcount;

  logic [8:0]          w_len;
  logic [31:0]         w_credit;
  logic                w_can_issue;
  logic                w_accept;
  logic                w_rdv;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic [23:0]         w_rem_after;
  logic [CW-1:0]       w_out_add;
  logic [CW-1:0]       w_out_sub;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_avm_read_nxt;
  logic [31:0]         w_avm_address_nxt;
  logic [8:0]          w_avm_burstcount_nxt;

  assign w_len       = (r_remaining >= 24'(BURST_LEN)) ? 9'(BURST_LEN) : r_remaining[8:0];
  // Room left once every word already requested has landed; fifo_count + outstanding never exceeds depth.
  assign w_credit    = 32'(FIFO_DEPTH) - 32'(r_fifo_count) - 32'(r_outstanding);
  assign w_can_issue = (w_credit >= 32'(w_len));
  assign w_accept    = (r_state == S_REQ) & r_avm_read & ~avm_waitrequest;
  assign w_rdv       = avm_readdatavalid & (r_state != S_IDLE);
  assign w_full      = (r_fifo_count == CW'(FIFO_DEPTH));
  assign w_push      = w_rdv & ~w_full;
  assign w_pop       = (r_fifo_count != {CW{1'b0}}) & pix_ready;
  assign w_rem_after = r_remaining - {15'd0, r_avm_burstcount};
  assign w_out_add   = w_accept ? CW'(r_avm_burstcount) : {CW{1'b0}};
  assign w_out_sub   = w_rdv ? CW'(1) : {CW{1'b0}};

  assign busy           = r_busy;
  assign done           = r_done;
  assign avm_read       = r_avm_read;
  assign avm_address    = r_avm_address;
  assign avm_burstcount = r_avm_burstcount;
  assign avm_byteenable = 4'hF;
  assign pix_data       = r_mem[r_rd_ptr];
  assign pix_valid      = (r_fifo_count != {CW{1'b0}});

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DRAIN looks ahead at the final beat so done follows it by one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (frame_words == 24'd0) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_state_nxt = S_ARB;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ARB: begin
        if (w_can_issue) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_ARB;
        end
      end
      S_REQ: begin
        if (w_accept) begin
          if (w_rem_after != 24'd0) begin
            w_state_nxt = S_ARB;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        if ((r_outstanding == {CW{1'b0}}) || ((r_outstanding == CW'(1)) && w_rdv)) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered bus and status outputs.
  always_comb begin
    w_avm_read_nxt       = 1'b0;
    w_avm_address_nxt    = r_avm_address;
    w_avm_burstcount_nxt = r_avm_burstcount;
    w_done_nxt           = (w_state_nxt == S_FINISH);
    w_busy_nxt           = (w_state_nxt == S_ARB) || (w_state_nxt == S_REQ) || (w_state_nxt == S_DRAIN);
    case (r_state)
      S_ARB: begin
        if (w_can_issue) begin
          w_avm_read_nxt       = 1'b1;
          w_avm_address_nxt    = r_addr;
          w_avm_burstcount_nxt = w_len;
        end else begin
          w_avm_read_nxt       = 1'b0;
        end
      end
      S_REQ: begin
        if (w_accept) begin
          w_avm_read_nxt = 1'b0;
        end else begin
          w_avm_read_nxt = 1'b1;
        end
      end
      default: w_avm_read_nxt = 1'b0;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_avm_read       <= 1'b0;
      r_avm_address    <= 32'd0;
      r_avm_burstcount <= 9'd0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      r_avm_read       <= w_avm_read_nxt;
      r_avm_address    <= w_avm_address_nxt;
      r_avm_burstcount <= w_avm_burstcount_nxt;
      r_busy           <= w_busy_nxt;
      r_done           <= w_done_nxt;
    end
  end

  // Frame cursor: latched on start, advanced by each accepted burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= 32'd0;
      r_remaining <= 24'd0;
    end else if ((r_state == S_IDLE) && start) begin
      r_addr      <= frame_base & ~32'h0000_0003;
      r_remaining <= frame_words;
    end else if (w_accept) begin
      r_addr      <= r_addr + {21'd0, r_avm_burstcount, 2'b00};
      r_remaining <= w_rem_after;
    end
  end

  // Words requested but not yet returned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= {CW{1'b0}};
    end else begin
      r_outstanding <= r_outstanding + w_out_add - w_out_sub;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= {AW{1'b0}};
      r_rd_ptr     <= {AW{1'b0}};
      r_fifo_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + CW'(1);
        2'b01:   r_fifo_count <= r_fifo_count - CW'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= avm_readdata;
    end
  end

`ifdef VFR_UNDERFLOW_CNT_EN
  logic [15:0] r_underflow_cnt;
  assign underflow_cnt = r_underflow_cnt;

  // Saturating count of cycles the sink wanted a pixel while a frame was in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underflow_cnt <= 16'd0;
    end else if ((r_state == S_IDLE) && start) begin
      r_underflow_cnt <= 16'd0;
    end else if (r_busy && pix_ready && !pix_valid && (r_underflow_cnt != 16'hFFFF)) begin
      r_underflow_cnt <= r_underflow_cnt + 16'd1;
    end
  end
`endif

  video_frame_reader_chk u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .rdv     (avm_readdatavalid),
    .full    (w_full)
  );

endmodule

// Protocol checker: read data must never arrive while the pixel FIFO is full.
module video_frame_reader_chk (
  input logic clk,
  input logic reset_n,
  input logic rdv,
  input logic full
);
  a_no_rdv_when_full: assert property (@(posedge clk) disable iff (!reset_n) !(rdv && full));
endmodule

// File: tb/tb_video_frame_reader.sv
// Self-checking bench for video_frame_reader: Avalon slave model, frame-level reference queues,
// table-driven frames, hand-written corner sequences and randomized frames.
module tb_video_frame_reader;

  localparam int BL    = 64;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] frame_base;
  logic [23:0] frame_words;
  logic        busy, done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [8:0]  avm_burstcount;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
`ifdef VFR_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  always #5 clk = ~clk;

  video_frame_reader dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .frame_base        (frame_base),
    .frame_words       (frame_words),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_burstcount    (avm_burstcount),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .pix_data          (pix_data),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready)
`ifdef VFR_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt     (underflow_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          cnt;
  } burst_t;

  typedef struct {
    logic [31:0] base;
    int          words;
    int          wn;
    int          mode;
    bit          gaps;
    int          exp_b;
  } vec_t;

  int n_chk = 0, n_pass = 0;
  burst_t      exp_bur[$];
  logic [31:0] exp_pix[$];
  logic [31:0] pending[$];
  int cyc = 0, start_cyc = -10, last_rdv_cyc = -10;
  int wait_n = 0, ready_mode = 1, stall_cnt = 0;
  bit rand_gaps = 1'b0;
  int burst_cnt, pix_cnt, done_cnt, read_hi, rcv_cnt, cur_words;
  int occ = 0, max_occ = 0, exp_uf = 0;
  bit prev_read = 1'b0, prev_wait = 1'b0, prev_acc = 1'b0, chk_busy_next = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [8:0]  prev_cnt = 9'd0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Slave model and scoreboard: inputs for the current cycle are set, then the cycle's handshakes observed.
  always @(negedge clk) begin
    burst_t eb;
    bit acc;
    cyc = cyc + 1;
    if (!reset_n) begin
      pending.delete(); exp_pix.delete(); exp_bur.delete();
      avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
      stall_cnt = 0; occ = 0; exp_uf = 0;
      prev_read = 1'b0; prev_wait = 1'b0; prev_acc = 1'b0; chk_busy_next = 1'b0;
    end else begin
      case (ready_mode)
        0:       pix_ready = 1'b0;
        1:       pix_ready = 1'b1;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      avm_waitrequest = avm_read && (stall_cnt < wait_n);
      if (pending.size() > 0 && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = memfn(pending.pop_front());
        rcv_cnt++; occ++; last_rdv_cyc = cyc;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom;
      end

      if (done) begin
        done_cnt++;
        check("done_busy_low", 32'(busy), 32'd0);
        if (cur_words == 0) check("done_latency_zero_len", 32'(cyc - start_cyc), 32'd1);
        else check("done_latency", 32'(cyc - last_rdv_cyc), 32'd1);
      end
      if (chk_busy_next) begin
        check("busy_after_start", 32'(busy), 32'd1);
        chk_busy_next = 1'b0;
      end
      if (start && !busy) begin
        start_cyc = cyc; exp_uf = 0; chk_busy_next = (cur_words != 0);
      end
      if (prev_acc) check("idle_gap_between_bursts", 32'(avm_read), 32'd0);
      if (prev_read && prev_wait) begin
        check("hold_read", 32'(avm_read), 32'd1);
        check("hold_addr", avm_address, prev_addr);
        check("hold_burstcount", 32'(avm_burstcount), 32'(prev_cnt));
      end

      acc = avm_read && !avm_waitrequest;
      if (avm_read) read_hi++;
      if (acc) begin
        burst_cnt++; stall_cnt = 0;
        if (exp_bur.size() == 0) begin
          check("burst_count_excess", 32'(burst_cnt), 32'(burst_cnt - 1));
        end else begin
          eb = exp_bur.pop_front();
          check("burst_addr", avm_address, eb.addr);
          check("burst_len", 32'(avm_burstcount), 32'(eb.cnt));
        end
        for (int i = 0; i < int'(avm_burstcount); i++) pending.push_back(avm_address + 32'(i) * 32'd4);
      end else if (avm_read) begin
        stall_cnt++;
      end

      if (busy && pix_ready && !pix_valid && exp_uf < 65535) exp_uf++;
      if (pix_valid && pix_ready) begin
        pix_cnt++; occ--;
        if (exp_pix.size() == 0) check("pix_count_excess", 32'(pix_cnt), 32'(cur_words));
        else check("pix_data", pix_data, exp_pix.pop_front());
      end
      if (occ > max_occ) max_occ = occ;

      prev_read = avm_read; prev_wait = avm_waitrequest; prev_acc = acc;
      prev_addr = avm_address; prev_cnt = avm_burstcount;
    end
  end

  task automatic begin_frame(input logic [31:0] base, input int words, input int wn, input int mode, input bit gaps);
    logic [31:0] a;
    burst_t b;
    wait_n = wn; ready_mode = mode; rand_gaps = gaps;
    burst_cnt = 0; pix_cnt = 0; done_cnt = 0; read_hi = 0; max_occ = 0; rcv_cnt = 0; cur_words = words;
    exp_bur.delete(); exp_pix.delete();
    a = base & ~32'h0000_0003;
    for (int off = 0; off < words; off += BL) begin
      b.addr = a + 32'(off) * 32'd4;
      b.cnt  = (words - off > BL) ? BL : words - off;
      exp_bur.push_back(b);
    end
    for (int i = 0; i < words; i++) exp_pix.push_back(memfn(a + 32'(i) * 32'd4));
    @(posedge clk); #1;
    frame_base = base; frame_words = 24'(words); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_frame(input int exp_b);
    int t;
    t = 0;
    while (done_cnt == 0 && t < 20000) begin @(posedge clk); t++; end
    check("done_seen", 32'(done_cnt > 0), 32'd1);
    while (exp_pix.size() != 0 && t < 40000) begin @(posedge clk); t++; end
    check("all_pixels_delivered", 32'(exp_pix.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("done_once", 32'(done_cnt), 32'd1);
    check("burst_total", 32'(burst_cnt), 32'(exp_b));
    check("bursts_outstanding_in_model", 32'(exp_bur.size()), 32'd0);
    check("pix_total", 32'(pix_cnt), 32'(cur_words));
    check("fifo_never_overflows", 32'(max_occ <= DEPTH), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    check("fifo_empty_after", 32'(pix_valid), 32'd0);
    if (cur_words == 0) check("no_read_zero_len", 32'(read_hi), 32'd0);
`ifdef VFR_UNDERFLOW_CNT_EN
    check("underflow_cnt", 32'(underflow_cnt), 32'(exp_uf));
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_avm_read"}, 32'(avm_read), 32'd0);
    check({tag, "_avm_address"}, avm_address, 32'd0);
    check({tag, "_avm_burstcount"}, 32'(avm_burstcount), 32'd0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
`ifdef VFR_UNDERFLOW_CNT_EN
    check({tag, "_underflow_cnt"}, 32'(underflow_cnt), 32'd0);
`endif
  endtask

  initial begin
    vec_t vt[6];
    int t, w;
    logic [31:0] rb;
    vt[0] = '{32'h3000_0000,  64, 0, 1, 1'b0, 1};
    vt[1] = '{32'h3000_0000, 150, 0, 1, 1'b0, 3};
    vt[2] = '{32'h3000_0000, 150, 5, 1, 1'b0, 3};
    vt[3] = '{32'h1234_5677,   0, 0, 1, 1'b0, 0};
    vt[4] = '{32'h3000_0003,  70, 2, 2, 1'b1, 2};
    vt[5] = '{32'hFFFF_FF00, 300, 1, 2, 1'b1, 5};

    reset_n = 1'b0; start = 1'b0; frame_base = 32'd0; frame_words = 24'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    check("byteenable", 32'(avm_byteenable), 32'h0000_000F);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 6; k++) begin
      begin_frame(vt[k].base, vt[k].words, vt[k].wn, vt[k].mode, vt[k].gaps);
      finish_frame(vt[k].exp_b);
    end

    // Backpressure: four bursts fill the credit, then issue must stop until the sink drains.
    begin_frame(32'h3000_0000, 1024, 0, 0, 1'b0);
    repeat (400) @(posedge clk);
    #1;
    check("bp_bursts_while_blocked", 32'(burst_cnt), 32'd4);
    check("bp_read_low", 32'(avm_read), 32'd0);
    check("bp_pix_valid", 32'(pix_valid), 32'd1);
    repeat (50) @(posedge clk);
    #1;
    check("bp_still_blocked", 32'(burst_cnt), 32'd4);
    ready_mode = 1;
    finish_frame(16);

    // A start while busy must be ignored.
    begin_frame(32'h2000_0000, 200, 1, 1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    frame_base = 32'h4000_0000; frame_words = 24'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_frame(4);

    // Reset while a burst is half returned, then a fresh frame.
    begin_frame(32'h3000_0000, 64, 0, 1, 1'b0);
    t = 0;
    while (rcv_cnt < 32 && t < 2000) begin @(posedge clk); t++; end
    check("half_burst_returned", 32'(rcv_cnt >= 32), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    begin_frame(32'h5000_0040, 64, 0, 1, 1'b0);
    finish_frame(1);

    for (int k = 0; k < 6; k++) begin
      rb = $urandom;
      w  = $urandom_range(1, 400);
      begin_frame(rb, w, $urandom_range(0, 3), $urandom_range(1, 2), 1'($urandom_range(0, 1)));
      finish_frame((w + BL - 1) / BL);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
